assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache.sv | 268 ++++++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// assoc_cache: fully-associative, write-through/no-allocate cache with LRU replacement.
// Defining ASSOC_CACHE_STATS_EN adds saturating read hit/miss counters (hit_cnt, miss_cnt).
module assoc_cache #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LINES  = 4
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic              req_en,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef ASSOC_CACHE_STATS_EN
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
`endif
    input  logic              mem_ack
);

    localparam int unsigned IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t              state_q, state_d;
    logic                req_rdy_q, req_rdy_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                hit_q, hit_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wr_hit_q, wr_hit_d;

    logic                valid_q [LINES];
    logic                valid_d [LINES];
    logic [ADDR_W-1:0]   tag_q   [LINES];
    logic [ADDR_W-1:0]   tag_d   [LINES];
    logic [DATA_W-1:0]   data_q  [LINES];
    logic [DATA_W-1:0]   data_d  [LINES];
    logic [IDX_W-1:0]    age_q   [LINES];
    logic [IDX_W-1:0]    age_d   [LINES];

    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic                found_inv;
    logic [IDX_W-1:0]    victim_idx;
    logic                touch_en;
    logic [IDX_W-1:0]    touch_idx;
    logic [IDX_W-1:0]    old_age;

    // Tag lookup against the incoming request address
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (!hit_any && valid_q[i] && (tag_q[i] == req_addr)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim: lowest invalid line, otherwise the oldest line
    always_comb begin
        found_inv  = 1'b0;
        victim_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (!found_inv && !valid_q[i]) begin
                found_inv  = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
        if (!found_inv) begin
            for (int i = 0; i < LINES; i++) begin
                if (age_q[i] == IDX_W'(LINES - 1)) begin
                    victim_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_rdy_d   = 1'b0;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        hit_d       = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_hit_d    = wr_hit_q;
        touch_en    = 1'b0;
        touch_idx   = '0;
        for (int i = 0; i < LINES; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            data_d[i]  = data_q[i];
        end

        case (state_q)
            IDLE: begin
                req_rdy_d = 1'b1;
                if (req_en) begin
                    if (req_rw) begin
                        state_d     = WR_THRU;
                        req_rdy_d   = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        wr_hit_d    = hit_any;
                        if (hit_any) begin
                            data_d[hit_idx] = req_wdata;
                            touch_en        = 1'b1;
                            touch_idx       = hit_idx;
                        end
                    end else if (hit_any) begin
                        rd_valid_d = 1'b1;
                        hit_d      = 1'b1;
                        rd_data_d  = data_q[hit_idx];
                        touch_en   = 1'b1;
                        touch_idx  = hit_idx;
                    end else begin
                        state_d    = RD_MISS;
                        req_rdy_d  = 1'b0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = req_addr;
                    end
                end
            end
            RD_MISS: begin
                if (mem_ack) begin
                    state_d            = IDLE;
                    req_rdy_d          = 1'b1;
                    rd_valid_d         = 1'b1;
                    rd_data_d          = mem_rdata;
                    valid_d[victim_idx] = 1'b1;
                    tag_d[victim_idx]   = mem_addr_q;
                    data_d[victim_idx]  = mem_rdata;
                    touch_en           = 1'b1;
                    touch_idx          = victim_idx;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WR_THRU: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    req_rdy_d = 1'b1;
                    hit_d     = wr_hit_q;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                req_rdy_d = 1'b1;
            end
        endcase

        // Touched line becomes youngest; lines younger than its old age shift up by one
        old_age = age_q[touch_idx];
        for (int i = 0; i < LINES; i++) begin
            age_d[i] = age_q[i];
            if (touch_en) begin
                if (IDX_W'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < old_age) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state_q     <= IDLE;
            req_rdy_q   <= 1'b1;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_hit_q    <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                age_q[i]   <= IDX_W'(i);
            end
        end else begin
            state_q     <= state_d;
            req_rdy_q   <= req_rdy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            hit_q       <= hit_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_hit_q    <= wr_hit_d;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= valid_d[i];
                age_q[i]   <= age_d[i];
            end
        end
        // Tag and data arrays are gated by valid bits, so they need no reset
        for (int i = 0; i < LINES; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
        end
    end

    assign req_rdy   = req_rdy_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign hit       = hit_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ASSOC_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Counts follow the read-completion strobes, saturating at all-ones
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rd_valid_d && hit_d && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (rd_valid_d && !hit_d && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    // counters omitted in this build
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed vector table, reset/busy sequences and random traffic
// checked against a queue-based LRU reference model.
module tb_assoc_cache;

    localparam int unsigned LINES = 4;

    logic       g_clk = 1'b0;
    logic       g_clr = 1'b0;
    logic       req_en = 1'b0;
    logic       req_rw = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_rdy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       hit;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
`ifdef ASSOC_CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    int          exp_hits;
    int          exp_miss;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] last_rd = 8'h00;

    logic [7:0] m_addr[$];
    logic [7:0] m_data[$];

    assoc_cache #(.DATA_W(8), .ADDR_W(8), .LINES(LINES)) dut (
        .g_clk    (g_clk),
        .g_clr    (g_clr),
        .req_en   (req_en),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_rdy  (req_rdy),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .hit      (hit),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef ASSOC_CACHE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .mem_ack  (mem_ack)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Reference model: queue ordered most-recent first; eviction drops the tail
    function automatic int mdl_find(input logic [7:0] a);
        for (int i = 0; i < m_addr.size(); i++) begin
            if (m_addr[i] == a) return i;
        end
        return -1;
    endfunction

    task automatic mdl_touch(input int idx);
        logic [7:0] a;
        logic [7:0] d;
        a = m_addr[idx];
        d = m_data[idx];
        m_addr.delete(idx);
        m_data.delete(idx);
        m_addr.push_front(a);
        m_data.push_front(d);
    endtask

    task automatic mdl_update(input bit rw, input logic [7:0] a, input logic [7:0] wd,
                              input logic [7:0] md);
        int idx;
        idx = mdl_find(a);
        if (rw) begin
            if (idx >= 0) begin
                m_data[idx] = wd;
                mdl_touch(idx);
            end
        end else if (idx >= 0) begin
            mdl_touch(idx);
`ifdef ASSOC_CACHE_STATS_EN
            exp_hits++;
`endif
        end else begin
            if (m_addr.size() == LINES) begin
                void'(m_addr.pop_back());
                void'(m_data.pop_back());
            end
            m_addr.push_front(a);
            m_data.push_front(md);
`ifdef ASSOC_CACHE_STATS_EN
            exp_miss++;
`endif
        end
    endtask

    task automatic do_reset();
        g_clr = 1'b1;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        chk1("rst/req_rdy", req_rdy, 1'b1);
        chk8("rst/rd_data", rd_data, 8'h00);
        chk1("rst/rd_valid", rd_valid, 1'b0);
        chk1("rst/hit", hit, 1'b0);
        chk1("rst/mem_req", mem_req, 1'b0);
        chk1("rst/mem_we", mem_we, 1'b0);
        chk8("rst/mem_addr", mem_addr, 8'h00);
        chk8("rst/mem_wdata", mem_wdata, 8'h00);
        g_clr = 1'b0;
        last_rd = 8'h00;
        m_addr.delete();
        m_data.delete();
`ifdef ASSOC_CACHE_STATS_EN
        chk8("rst/hit_cnt", 8'(hit_cnt), 8'h00);
        chk8("rst/miss_cnt", 8'(miss_cnt), 8'h00);
        exp_hits = 0;
        exp_miss = 0;
`endif
    endtask

    // One request: accept, serve memory handshake if any, check completion and the idle cycle after
    task automatic xact(input bit rw, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] md, input int dly, input bit spam,
                        input bit eh, input logic [7:0] ed, input string nm);
        int n;
        req_en = 1'b1;
        req_rw = rw;
        req_addr = a;
        req_wdata = wd;
        @(posedge g_clk); #1;
        req_en = 1'b0;
        if (!rw && eh) begin
            chk1({nm, "/mem_req"}, mem_req, 1'b0);
            chk1({nm, "/rd_valid"}, rd_valid, 1'b1);
            chk1({nm, "/hit"}, hit, 1'b1);
            chk8({nm, "/rd_data"}, rd_data, ed);
            last_rd = ed;
        end else begin
            n = 1;
            while (n <= 16) begin
                chk1({nm, "/mem_req"}, mem_req, 1'b1);
                chk1({nm, "/mem_we"}, mem_we, rw);
                chk8({nm, "/mem_addr"}, mem_addr, a);
                chk1({nm, "/req_rdy_busy"}, req_rdy, 1'b0);
                if (rw) chk8({nm, "/mem_wdata"}, mem_wdata, wd);
                if (mem_req !== 1'b1 || n >= dly) break;
                if (spam) begin
                    req_en = 1'b1;
                    req_rw = 1'b0;
                    req_addr = a ^ 8'h01;
                end
                @(posedge g_clk); #1;
                n++;
            end
            req_en = 1'b0;
            req_addr = a;
            mem_ack = 1'b1;
            mem_rdata = md;
            @(posedge g_clk); #1;
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
            chk1({nm, "/done_rd_valid"}, rd_valid, !rw);
            chk1({nm, "/done_hit"}, hit, eh);
            chk1({nm, "/done_req_rdy"}, req_rdy, 1'b1);
            chk1({nm, "/done_mem_req"}, mem_req, 1'b0);
            if (!rw) begin
                chk8({nm, "/done_rd_data"}, rd_data, ed);
                last_rd = ed;
            end else begin
                chk8({nm, "/wr_rd_data_hold"}, rd_data, last_rd);
            end
        end
        @(posedge g_clk); #1;
        chk1({nm, "/idle_rd_valid"}, rd_valid, 1'b0);
        chk1({nm, "/idle_hit"}, hit, 1'b0);
        chk1({nm, "/idle_mem_req"}, mem_req, 1'b0);
        chk8({nm, "/idle_rd_data"}, rd_data, last_rd);
        mdl_update(rw, a, wd, md);
    endtask

    typedef struct {
        bit         clr;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] mdata;
        int         dly;
        bit         eh;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // clr, rw, addr, wdata, mem_rdata, ack delay, expected hit, expected rd_data
        tbl[0]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 3, 1'b0, 8'h5A};
        tbl[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1, 1'b1, 8'h5A};
        tbl[2]  = '{1'b0, 1'b1, 8'h10, 8'h33, 8'h00, 2, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1, 1'b1, 8'h33};
        tbl[4]  = '{1'b0, 1'b1, 8'h20, 8'h44, 8'h00, 1, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h66, 2, 1'b0, 8'h66};
        tbl[6]  = '{1'b1, 1'b0, 8'h01, 8'h00, 8'hA1, 1, 1'b0, 8'hA1};
        tbl[7]  = '{1'b0, 1'b0, 8'h02, 8'h00, 8'hA2, 2, 1'b0, 8'hA2};
        tbl[8]  = '{1'b0, 1'b0, 8'h03, 8'h00, 8'hA3, 1, 1'b0, 8'hA3};
        tbl[9]  = '{1'b0, 1'b0, 8'h04, 8'h00, 8'hA4, 1, 1'b0, 8'hA4};
        tbl[10] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1, 1'b1, 8'hA1};
        tbl[11] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'hA5, 1, 1'b0, 8'hA5};
        tbl[12] = '{1'b0, 1'b0, 8'h02, 8'h00, 8'hB2, 1, 1'b0, 8'hB2};
        tbl[13] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1, 1'b1, 8'hA1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].clr) do_reset();
            xact(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].mdata, tbl[i].dly, 1'b0,
                 tbl[i].eh, tbl[i].ed, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a read miss; the late ack must not fill or complete
        req_en = 1'b1; req_rw = 1'b0; req_addr = 8'h77;
        @(posedge g_clk); #1;
        req_en = 1'b0;
        @(posedge g_clk); #1;
        chk1("abort/mem_req_before", mem_req, 1'b1);
        g_clr = 1'b1;
        @(posedge g_clk); #1;
        g_clr = 1'b0;
        chk1("abort/req_rdy", req_rdy, 1'b1);
        chk1("abort/mem_req", mem_req, 1'b0);
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(posedge g_clk); #1;
        mem_ack = 1'b0;
        chk1("abort/late_ack_rd_valid", rd_valid, 1'b0);
        chk1("abort/late_ack_req_rdy", req_rdy, 1'b1);
        chk1("abort/late_ack_mem_req", mem_req, 1'b0);
        m_addr.delete();
        m_data.delete();
        last_rd = 8'h00;
`ifdef ASSOC_CACHE_STATS_EN
        exp_hits = 0;
        exp_miss = 0;
`endif
        xact(1'b0, 8'h77, 8'h00, 8'h12, 2, 1'b0, 1'b0, 8'h12, "abort_reread");

        // Counter scenario: two misses then three hits, then a write with requests spammed while busy
        do_reset();
        xact(1'b0, 8'h40, 8'h00, 8'hC0, 1, 1'b0, 1'b0, 8'hC0, "st_m0");
        xact(1'b0, 8'h41, 8'h00, 8'hC1, 2, 1'b0, 1'b0, 8'hC1, "st_m1");
        xact(1'b0, 8'h40, 8'h00, 8'h00, 1, 1'b0, 1'b1, 8'hC0, "st_h0");
        xact(1'b0, 8'h41, 8'h00, 8'h00, 1, 1'b0, 1'b1, 8'hC1, "st_h1");
        xact(1'b0, 8'h40, 8'h00, 8'h00, 1, 1'b0, 1'b1, 8'hC0, "st_h2");
`ifdef ASSOC_CACHE_STATS_EN
        chk8("stats/hit_cnt", 8'(hit_cnt), 8'd3);
        chk8("stats/miss_cnt", 8'(miss_cnt), 8'd2);
`endif
        xact(1'b1, 8'h40, 8'h99, 8'h00, 4, 1'b1, 1'b1, 8'h00, "busy_wr");
        chk1("busy/no_extra_rd_valid", rd_valid, 1'b0);
`ifdef ASSOC_CACHE_STATS_EN
        chk8("busy/hit_cnt", 8'(hit_cnt), 8'd3);
        chk8("busy/miss_cnt", 8'(miss_cnt), 8'd2);
`endif
        xact(1'b0, 8'h40, 8'h00, 8'h00, 1, 1'b0, 1'b1, 8'h99, "busy_reread");

        // Random traffic over a small address pool against the reference model
        for (int k = 0; k < 300; k++) begin
            bit         rw;
            logic [7:0] a;
            logic [7:0] wd;
            logic [7:0] md;
            int         idx;
            bit         eh;
            logic [7:0] ed;
            rw  = ($urandom_range(9, 0) < 3);
            a   = 8'h80 + 8'($urandom_range(6, 0));
            wd  = 8'($urandom);
            md  = 8'($urandom);
            idx = mdl_find(a);
            eh  = (idx >= 0);
            ed  = rw ? 8'h00 : (eh ? m_data[idx] : md);
            xact(rw, a, wd, md, $urandom_range(4, 1), 1'b0, eh, ed, $sformatf("rnd%0d", k));
        end
`ifdef ASSOC_CACHE_STATS_EN
        chk8("rnd/hit_cnt_lo", 8'(hit_cnt), 8'(exp_hits));
        chk8("rnd/miss_cnt_lo", 8'(miss_cnt), 8'(exp_miss));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
